mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Fixed-latency word memory responder: accepts one read/write request, answers
// with a single-cycle mem_resp after LATENCY edges, and keeps sticky error flags.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        addr_err,
  output logic        protocol_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned WA_W  = 15;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WA_W-1:0]    waddr_q, waddr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic               wr_q, wr_d;
  logic               both_q, both_d;
  logic [15:0]        rdata_q, rdata_d;
  logic               resp_q, resp_d;
  logic               aerr_q, aerr_d;
  logic               perr_q, perr_d;

  logic [15:0]        mem_q [DEPTH];

  logic                  go_resp_c;
  logic                  in_range_c;
  logic [DEPTH_LOG2-1:0] widx_c;
  logic                  mem_we_c;
  logic                  unused_addr0_c;

  // Byte address bit 0 carries no information for word accesses.
  assign unused_addr0_c = mem_address[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_read || mem_write) state_d = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; the *_d transaction fields describe the
  // transaction being completed so LATENCY=1 uses the inputs directly.
  always_comb begin
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    both_d  = both_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          waddr_d = mem_address[15:1];
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          wr_d    = mem_write;
          both_d  = mem_read & mem_write;
        end
      end
      BUSY:    cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    go_resp_c  = (state_d == RESP);
    in_range_c = ((waddr_d >> DEPTH_LOG2) == '0);
    widx_c     = waddr_d[DEPTH_LOG2-1:0];
    mem_we_c   = go_resp_c & wr_d & in_range_c & rst_n;

    resp_d  = go_resp_c;
    rdata_d = rdata_q;
    if (go_resp_c && !wr_d) rdata_d = in_range_c ? mem_q[widx_c] : 16'h0000;
    aerr_d  = aerr_q | (go_resp_c & ~in_range_c);
    perr_d  = perr_q | (go_resp_c & both_d);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      aerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      both_q  <= both_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      aerr_q  <= aerr_d;
      perr_q  <= perr_d;
    end
  end

  // Storage is intentionally not reset; per-lane write on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      if (be_d[0]) mem_q[widx_c][7:0]  <= wdata_d[7:0];
      if (be_d[1]) mem_q[widx_c][15:8] <= wdata_d[15:8];
    end
  end

  assign mem_rdata    = rdata_q;
  assign mem_resp     = resp_q;
  assign addr_err     = aerr_q;
  assign protocol_err = perr_q;

endmodule
